nbit_mosi_spi_receiver: RTL

NBIT_MOSI_SPI_RECEIVER -- requirements
Module: nbit_mosi_spi_receiver

---
 rtl/nbit_mosi_spi_receiver_pkg.sv | 13 +
 rtl/nbit_mosi_spi_receiver_sync_edge_detect.sv | 35 +++
 rtl/nbit_mosi_spi_receiver.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nbit_mosi_spi_receiver_pkg.sv
// Shared definitions for the N-byte MOSI SPI receiver: FSM state encoding
// and the default geometry of a frame.
package nbit_mosi_spi_receiver_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/nbit_mosi_spi_receiver_sync_edge_detect.sv
// Two-flop synchronizer followed by a registered edge detector. RST_VAL sets
// every flop at reset, so a line that idles at RST_VAL shows no edge on release.
module sync_edge_detect
    import nbit_mosi_spi_receiver_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_ASYNC,
    output logic o_RISE,
    output logic o_FALL
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronize the asynchronous line and keep one cycle of history for edges.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= i_ASYNC;
            sync <= meta;
            prev <= sync;
        end
    end

    assign o_RISE = sync & ~prev;
    assign o_FALL = ~sync & prev;

endmodule

// File: rtl/nbit_mosi_spi_receiver.sv
// SPI slave receive path: collects N bytes of WIDTH bits (MSB first) per frame,
// with one D/C bit per byte. Short frames are delivered on CS release;
// a CS release mid-byte drops the partial byte and flags a frame error.
//
//   state | meaning
//   IDLE  | CS high, SCK ignored, waiting for a CS falling edge
//   RECV  | CS low, shifting bits and filling frame slots
module nbit_mosi_spi_receiver
    import nbit_mosi_spi_receiver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic                   i_SCK,
    input  logic                   i_CS,
    input  logic                   i_MOSI,
    input  logic                   i_DC,
    output logic [WIDTH*N-1:0]     o_DATA,
    output logic [N-1:0]           o_DC,
    output logic [WIDTH-1:0]       o_BYTE,
    output logic                   o_BYTE_VALID,
    output logic                   o_FRAME_VALID,
    output logic [$clog2(N+1)-1:0] o_N_RECEIVED,
    output logic                   o_ERR_FRAME,
    output logic                   o_BUSY
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(N + 1);

    logic sck_rise;
    logic sck_fall_unused;
    logic cs_rise;
    logic cs_fall;

    sync_edge_detect #(.RST_VAL(1'b0)) u_sck_sync (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_ASYNC (i_SCK),
        .o_RISE  (sck_rise),
        .o_FALL  (sck_fall_unused)
    );

    sync_edge_detect #(.RST_VAL(1'b1)) u_cs_sync (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_ASYNC (i_CS),
        .o_RISE  (cs_rise),
        .o_FALL  (cs_fall)
    );

    logic mosi_d1, mosi_a;
    logic dc_d1, dc_a;

    // Delay MOSI and DC by the synchronizer depth so they line up with the SCK edge.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            mosi_d1 <= 1'b0;
            mosi_a  <= 1'b0;
            dc_d1   <= 1'b0;
            dc_a    <= 1'b0;
        end else begin
            mosi_d1 <= i_MOSI;
            mosi_a  <= mosi_d1;
            dc_d1   <= i_DC;
            dc_a    <= dc_d1;
        end
    end

    state_t             state;
    logic [WIDTH-1:0]   shift_q, shift_s;
    logic [BW-1:0]      bit_q, bit_s;
    logic [CW-1:0]      cnt_q, cnt_s;
    logic [WIDTH*N-1:0] buf_q, buf_s;
    logic [N-1:0]       dcb_q, dcb_s;
    logic               byte_done;
    logic               frame_full;

    // Apply this cycle's SCK edge first so a simultaneous CS rise sees updated counters.
    always_comb begin
        shift_s    = shift_q;
        bit_s      = bit_q;
        cnt_s      = cnt_q;
        buf_s      = buf_q;
        dcb_s      = dcb_q;
        byte_done  = 1'b0;
        frame_full = 1'b0;
        if (state == RECV && sck_rise) begin
            shift_s = {shift_q[WIDTH-2:0], mosi_a};
            if (bit_q == BW'(WIDTH - 1)) begin
                byte_done = 1'b1;
                bit_s     = '0;
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) begin
                        buf_s[k*WIDTH +: WIDTH] = shift_s;
                        dcb_s[k]                = dc_a;
                    end
                end
                if (cnt_q == CW'(N - 1)) begin
                    frame_full = 1'b1;
                    cnt_s      = '0;
                end else begin
                    cnt_s = cnt_q + 1'b1;
                end
            end else begin
                bit_s = bit_q + 1'b1;
            end
        end
    end

    // FSM, frame buffer and registered strobes/outputs.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state         <= IDLE;
            shift_q       <= '0;
            bit_q         <= '0;
            cnt_q         <= '0;
            buf_q         <= '0;
            dcb_q         <= '0;
            o_DATA        <= '0;
            o_DC          <= '0;
            o_BYTE        <= '0;
            o_BYTE_VALID  <= 1'b0;
            o_FRAME_VALID <= 1'b0;
            o_N_RECEIVED  <= '0;
            o_ERR_FRAME   <= 1'b0;
        end else begin
            o_BYTE_VALID  <= 1'b0;
            o_FRAME_VALID <= 1'b0;
            o_ERR_FRAME   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= RECV;
                        shift_q <= '0;
                        bit_q   <= '0;
                        cnt_q   <= '0;
                        buf_q   <= '0;
                        dcb_q   <= '0;
                    end
                end
                RECV: begin
                    shift_q <= shift_s;
                    bit_q   <= bit_s;
                    cnt_q   <= cnt_s;
                    buf_q   <= buf_s;
                    dcb_q   <= dcb_s;
                    if (byte_done) begin
                        o_BYTE       <= shift_s;
                        o_BYTE_VALID <= 1'b1;
                    end
                    // Full frame: deliver and restart slot filling so the next frame starts clean.
                    if (frame_full) begin
                        o_DATA        <= buf_s;
                        o_DC          <= dcb_s;
                        o_N_RECEIVED  <= CW'(N);
                        o_FRAME_VALID <= 1'b1;
                        buf_q         <= '0;
                        dcb_q         <= '0;
                    end
                    if (cs_rise) begin
                        state <= IDLE;
                        if (bit_s != '0) begin
                            o_ERR_FRAME <= 1'b1;
                        end
                        if (cnt_s != '0) begin
                            o_DATA        <= buf_s;
                            o_DC          <= dcb_s;
                            o_N_RECEIVED  <= cnt_s;
                            o_FRAME_VALID <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_BUSY = (state == RECV);

endmodule
